// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
//   Frequency-sweep sequencer for the DDS sine/cosine core. Steps the DDS
//   tuning word from a start word up to an inclusive stop word in fixed
//   increments. Each point is held for a programmable number of clk cycles.
//   Supports single-shot sweeps and repeating sweeps.
//
// Ports
//   clk            in   system clock (DDS clock domain)
//   rst            in   asynchronous active-high reset
//   cfg_start_ftw  in   first tuning word of the sweep
//   cfg_stop_ftw   in   inclusive upper bound tuning word
//   cfg_step_ftw   in   increment per point
//   cfg_dwell      in   clk cycles each point is held (0 behaves as 1)
//   cfg_repeat     in   1 = wrap to start after the last point, 0 = single shot
//   start          in   one-cycle pulse, begins a sweep when idle
//   abort          in   one-cycle pulse, stops the sweep immediately
//   dds_data       out  tuning word to the DDS data input
//   dds_we         out  one-cycle write strobe to the DDS
//   busy           out  high from accepted start until done/abort
//   sweep_done     out  one-cycle pulse at the end of a single-shot sweep
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; configuration is sampled on acceptance
// LOAD   | present cur to the DDS with a write strobe, arm dwell counter
// DWELL  | hold the current point until the dwell counter reaches 1
// STEP   | compute the next point or decide that the pass has ended
// DONE   | single-shot sweep finished; pulse sweep_done, drop busy

module dds_sweep_ctrl #(
  parameter int FTW_W   = 29,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FTW_W-1:0]   cfg_start_ftw,
  input  logic [FTW_W-1:0]   cfg_stop_ftw,
  input  logic [FTW_W-1:0]   cfg_step_ftw,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [FTW_W-1:0]   dds_data,
  output logic               dds_we,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DWELL = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [FTW_W-1:0]   cur_q, cur_d;
  logic [FTW_W-1:0]   start_ftw_q, start_ftw_d;
  logic [FTW_W-1:0]   stop_ftw_q, stop_ftw_d;
  logic [FTW_W-1:0]   step_ftw_q, step_ftw_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               repeat_q, repeat_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [FTW_W-1:0]   dds_data_q, dds_data_d;
  logic               dds_we_q, dds_we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // One extra bit so an overflowing step is seen as a carry, never a wrap.
  logic [FTW_W:0]     next_ftw;
  logic               pass_end;

  assign next_ftw = {1'b0, cur_q} + {1'b0, step_ftw_q};
  assign pass_end = (step_ftw_q == '0) || next_ftw[FTW_W] ||
                    (next_ftw[FTW_W-1:0] > stop_ftw_q);

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    start_ftw_d = start_ftw_q;
    stop_ftw_d  = stop_ftw_q;
    step_ftw_d  = step_ftw_q;
    dwell_d     = dwell_q;
    repeat_d    = repeat_q;
    cnt_d       = cnt_q;
    dds_data_d  = dds_data_q;
    dds_we_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          start_ftw_d = cfg_start_ftw;
          stop_ftw_d  = cfg_stop_ftw;
          step_ftw_d  = cfg_step_ftw;
          // Clamp here so the dwell counter never has to handle zero.
          dwell_d     = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
          repeat_d    = cfg_repeat;
          cur_d       = cfg_start_ftw;
          busy_d      = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        dds_data_d = cur_q;
        dds_we_d   = 1'b1;
        cnt_d      = dwell_q;
        state_d    = S_DWELL;
      end
      S_DWELL: begin
        if (cnt_q <= DWELL_W'(1)) begin
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      S_STEP: begin
        if (pass_end) begin
          if (repeat_q) begin
            cur_d   = start_ftw_q;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cur_d   = next_ftw[FTW_W-1:0];
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides everything, including a strobe LOAD would issue now.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      dds_we_d   = 1'b0;
      done_d     = 1'b0;
      dds_data_d = dds_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      start_ftw_q <= '0;
      stop_ftw_q  <= '0;
      step_ftw_q  <= '0;
      dwell_q     <= '0;
      repeat_q    <= 1'b0;
      cnt_q       <= '0;
      dds_data_q  <= '0;
      dds_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      start_ftw_q <= start_ftw_d;
      stop_ftw_q  <= stop_ftw_d;
      step_ftw_q  <= step_ftw_d;
      dwell_q     <= dwell_d;
      repeat_q    <= repeat_d;
      cnt_q       <= cnt_d;
      dds_data_q  <= dds_data_d;
      dds_we_q    <= dds_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dds_data   = dds_data_q;
  assign dds_we     = dds_we_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: fixed sweeps with hand-computed strobe
// values and spacings, abort and reset behaviour.

module tb_dds_sweep_ctrl;

  localparam int FTW_W   = 29;
  localparam int DWELL_W = 24;

  logic               clk = 1'b0;
  logic               rst;
  logic [FTW_W-1:0]   cfg_start_ftw;
  logic [FTW_W-1:0]   cfg_stop_ftw;
  logic [FTW_W-1:0]   cfg_step_ftw;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_repeat;
  logic               start;
  logic               abort;
  logic [FTW_W-1:0]   dds_data;
  logic               dds_we;
  logic               busy;
  logic               sweep_done;

  int checks = 0;
  int errors = 0;

  dds_sweep_ctrl #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start_ftw(cfg_start_ftw),
    .cfg_stop_ftw (cfg_stop_ftw),
    .cfg_step_ftw (cfg_step_ftw),
    .cfg_dwell    (cfg_dwell),
    .cfg_repeat   (cfg_repeat),
    .start        (start),
    .abort        (abort),
    .dds_data     (dds_data),
    .dds_we       (dds_we),
    .busy         (busy),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input longint s, input longint e, input longint st,
                     input longint dw, input logic rp);
    cfg_start_ftw = FTW_W'(s);
    cfg_stop_ftw  = FTW_W'(e);
    cfg_step_ftw  = FTW_W'(st);
    cfg_dwell     = DWELL_W'(dw);
    cfg_repeat    = rp;
  endtask

  // Pulse start for one edge; busy must rise and no strobe yet.
  task automatic kick(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_up"}, busy, 1);
    chk({tag, "_no_we_yet"}, dds_we, 0);
  endtask

  // Expect the next strobe exactly gap edges from now, with nothing earlier.
  task automatic point(input string tag, input int gap, input longint exp_data);
    int early;
    early = 0;
    for (int i = 1; i < gap; i++) begin
      tick();
      if (dds_we || sweep_done) early++;
    end
    tick();
    chk({tag, "_quiet"}, early, 0);
    chk({tag, "_we"}, dds_we, 1);
    chk({tag, "_data"}, dds_data, exp_data);
  endtask

  // Expect sweep_done exactly gap edges after the last strobe.
  task automatic done_after(input string tag, input int gap, input longint last_data);
    int early;
    early = 0;
    for (int i = 1; i < gap; i++) begin
      tick();
      if (dds_we || sweep_done) early++;
    end
    tick();
    chk({tag, "_quiet"}, early, 0);
    chk({tag, "_done"}, sweep_done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_hold"}, dds_data, last_data);
    tick();
    chk({tag, "_done_1cyc"}, sweep_done, 0);
  endtask

  initial begin
    int cnt_we;
    int cnt_done;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg(0, 0, 0, 0, 1'b0);
    #2;
    chk("rst_data", dds_data, 0);
    chk("rst_we", dds_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    rst = 1'b0;
    tick();

    // 1: basic single-shot sweep, dwell 3 -> spacing 5
    cfg(100, 400, 100, 3, 1'b0);
    kick("t1");
    point("t1_p0", 1, 100);
    point("t1_p1", 5, 200);
    point("t1_p2", 5, 300);
    point("t1_p3", 5, 400);
    done_after("t1_end", 5, 400);

    // 2: stop not hit exactly, 300 must never appear
    cfg(0, 250, 100, 1, 1'b0);
    kick("t2");
    point("t2_p0", 1, 0);
    point("t2_p1", 3, 100);
    point("t2_p2", 3, 200);
    done_after("t2_end", 3, 200);

    // 3: repeat mode, then abort in the cycle a strobe would be issued
    cfg(100, 200, 100, 2, 1'b1);
    kick("t3");
    point("t3_p0", 1, 100);
    point("t3_p1", 4, 200);
    point("t3_p2", 4, 100);
    point("t3_p3", 4, 200);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_abort_busy", busy, 0);
    chk("t3_abort_we", dds_we, 0);
    cnt_we = 0;
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dds_we) cnt_we++;
      if (sweep_done) cnt_done++;
    end
    chk("t3_after_we", cnt_we, 0);
    chk("t3_after_done", cnt_done, 0);
    chk("t3_after_hold", dds_data, 200);

    // 4a: carry out of the accumulator width ends the sweep
    cfg(536870902, 536870911, 20, 1, 1'b0);
    kick("t4a");
    point("t4a_p0", 1, 536870902);
    done_after("t4a_end", 3, 536870902);

    // 4b: zero step gives a single point
    cfg(50, 1000, 0, 2, 1'b0);
    kick("t4b");
    point("t4b_p0", 1, 50);
    done_after("t4b_end", 4, 50);

    // 4c: dwell 0 behaves as 1 -> spacing 3
    cfg(10, 30, 10, 0, 1'b0);
    kick("t4c");
    point("t4c_p0", 1, 10);
    point("t4c_p1", 3, 20);
    point("t4c_p2", 3, 30);
    done_after("t4c_end", 3, 30);

    // 4d: start above stop emits the start point once
    cfg(500, 100, 10, 1, 1'b0);
    kick("t4d");
    point("t4d_p0", 1, 500);
    done_after("t4d_end", 3, 500);

    // 5: restart and cfg change mid-sweep are ignored
    cfg(100, 300, 100, 3, 1'b0);
    kick("t5");
    point("t5_p0", 1, 100);
    cfg(999, 5000, 7, 1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    point("t5_p1", 4, 200);
    point("t5_p2", 5, 300);
    done_after("t5_end", 5, 300);

    // 5b: start and abort together in IDLE start nothing
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t5b_busy", busy, 0);
    cnt_we = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dds_we || busy) cnt_we++;
    end
    chk("t5b_idle", cnt_we, 0);

    // 6: async reset between edges mid-dwell, then a clean sweep
    cfg(100, 400, 100, 3, 1'b0);
    kick("t6");
    point("t6_p0", 1, 100);
    point("t6_p1", 5, 200);
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_data", dds_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_we", dds_we, 0);
    chk("t6_rst_done", sweep_done, 0);
    rst = 1'b0;
    tick();
    chk("t6_idle_busy", busy, 0);
    cfg(300, 500, 100, 1, 1'b0);
    kick("t6r");
    point("t6r_p0", 1, 300);
    point("t6r_p1", 3, 400);
    point("t6r_p2", 3, 500);
    done_after("t6r_end", 3, 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
